// File: rtl/imm_ext_pipe.sv
// Decode-stage immediate generator (I/S/B/J/U/zimm) feeding a DEPTH-entry in-order
// valid/ready buffer with synchronous flush and an illegal-format flag.
module imm_ext_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [24:0]     instr,
    input  logic [2:0]      immsrc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic            ill;
        logic [XLEN-1:0] imm;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            r_in_ready;

    logic [31:0]     w_imm32;
    entry_t          w_ent;
    logic            w_push, w_pop;
    logic [CW-1:0]   w_cnt_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // instr holds instruction bits [31:7], so instruction bit k lives at instr[k-7]
    always_comb begin
        w_imm32 = '0;
        w_ent   = '0;
        case (immsrc)
            3'b000:  w_imm32 = {{20{instr[24]}}, instr[24:13]};
            3'b001:  w_imm32 = {{20{instr[24]}}, instr[24:18], instr[4:0]};
            3'b010:  w_imm32 = {{19{instr[24]}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
            3'b011:  w_imm32 = {{11{instr[24]}}, instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
            3'b100:  w_imm32 = {instr[24:5], 12'b0};
            default: w_imm32 = '0;
        endcase
        w_ent.imm = XLEN'($signed(w_imm32));
        if (immsrc == 3'b101)
            w_ent.imm = XLEN'(instr[12:8]);
        if (immsrc[2:1] == 2'b11) begin
            w_ent.imm = '0;
            w_ent.ill = 1'b1;
        end
    end

    assign out_valid = (r_count != '0);
    assign in_ready  = r_in_ready;
    assign w_push    = in_valid && r_in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_count + 1'b1;
            2'b01:   w_cnt_nxt = r_count - 1'b1;
            default: w_cnt_nxt = r_count;
        endcase
    end

    // Stale entries stay in r_mem after a pop/flush; outputs are gated by count instead.
    assign out_imm     = out_valid ? r_mem[r_rd_ptr].imm : '0;
    assign out_illegal = out_valid ? r_mem[r_rd_ptr].ill : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_ent;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count    <= w_cnt_nxt;
            r_in_ready <= (w_cnt_nxt != CW'(DEPTH));
        end
    end
endmodule
